// File: rtl/gray_win3x3_gen_if.sv
// Pixel-stream bundle for gray_win3x3_gen: Y stream with syncs in,
// 3x3 window with delayed syncs, valid and border flag out.
interface gray_win3x3_gen_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  hsync;
   logic                  vsync;
   logic                  de;

   logic [DATA_WIDTH-1:0] p11, p12, p13;
   logic [DATA_WIDTH-1:0] p21, p22, p23;
   logic [DATA_WIDTH-1:0] p31, p32, p33;
   logic                  o_hsync;
   logic                  o_vsync;
   logic                  o_de;
   logic                  o_border;

   modport master (
      output in_data, hsync, vsync, de,
      input  p11, p12, p13, p21, p22, p23, p31, p32, p33,
      input  o_hsync, o_vsync, o_de, o_border
   );

   modport slave (
      input  in_data, hsync, vsync, de,
      output p11, p12, p13, p21, p22, p23, p31, p32, p33,
      output o_hsync, o_vsync, o_de, o_border
   );
endinterface

// File: rtl/gray_win3x3_gen.sv
// Streaming causal 3x3 window generator for the gray path, two line RAMs deep.
// Build macro WIN3X3_EDGE_REPLICATE_EN: out-of-image taps replicate the nearest pixel instead of 0.
module gray_win3x3_gen #(
   parameter int   DATA_WIDTH = 8,
   parameter int   IMG_WIDTH  = 1280,
   parameter int   IMG_HEIGHT = 720,
   parameter logic VS_ACTIVE  = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   gray_win3x3_gen_if.slave bus
);
   localparam int CW = $clog2(IMG_WIDTH + 1);
   localparam int RW = $clog2(IMG_HEIGHT + 1);
   localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT);

   typedef logic [DATA_WIDTH-1:0] pix_t;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          de_q;
   logic          acc;
   logic [AW-1:0] addr;

   pix_t lb1_mem [IMG_WIDTH];
   pix_t lb2_mem [IMG_WIDTH];
   pix_t lb1_rd_p1_q, lb2_rd_p1_q;

   pix_t          in_p1_q;
   logic          vld_p1_q, hs_p1_q, vs_p1_q;
   logic [CW-1:0] col_p1_q;
   logic [RW-1:0] row_p1_q;

   pix_t       h1_q [2];
   pix_t       h2_q [2];
   pix_t       h3_q [2];
   pix_t       raw   [3][3];
   pix_t       win_d [3][3];
   pix_t       win_q [3][3];
   logic [1:0] vmin, hmin;
   logic       border_d;
   logic       o_de_q, o_border_q, o_hs_q, o_vs_q;

   assign acc  = bus.de && (col_q < COL_MAX);
   assign addr = col_q[AW-1:0];

   always_comb begin
      col_d = '0;
      if (bus.de) col_d = (col_q == COL_MAX) ? col_q : col_q + CW'(1);
   end

   // vsync blanking clear takes priority over the end-of-line increment
   always_comb begin
      row_d = row_q;
      if (bus.vsync == VS_ACTIVE)                       row_d = '0;
      else if (de_q && !bus.de && (row_q != ROW_MAX))   row_d = row_q + RW'(1);
   end

   // ---- stage p0 -> p1: counters, line RAM read-before-write, input alignment
   always_ff @(posedge clk) begin
      if (acc) begin
         lb1_rd_p1_q   <= lb1_mem[addr];
         lb2_rd_p1_q   <= lb2_mem[addr];
         lb1_mem[addr] <= bus.in_data;
         lb2_mem[addr] <= lb1_mem[addr];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q    <= '0;
         row_q    <= '0;
         de_q     <= 1'b0;
         in_p1_q  <= '0;
         vld_p1_q <= 1'b0;
         hs_p1_q  <= 1'b0;
         vs_p1_q  <= 1'b0;
         col_p1_q <= '0;
         row_p1_q <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         de_q     <= bus.de;
         vld_p1_q <= acc;
         hs_p1_q  <= bus.hsync;
         vs_p1_q  <= bus.vsync;
         if (acc) begin
            in_p1_q  <= bus.in_data;
            col_p1_q <= col_q;
            row_p1_q <= row_q;
         end
      end
   end

   // Row index 0 = line y-2, 2 = line y; column index 0 = x-2, 2 = x
   always_comb begin
      raw[0][2] = lb2_rd_p1_q;  raw[0][1] = h1_q[0];  raw[0][0] = h1_q[1];
      raw[1][2] = lb1_rd_p1_q;  raw[1][1] = h2_q[0];  raw[1][0] = h2_q[1];
      raw[2][2] = in_p1_q;      raw[2][1] = h3_q[0];  raw[2][0] = h3_q[1];
   end

   // vmin/hmin: lowest tap index that lies inside the image for this pixel
   always_comb begin
      vmin     = (row_p1_q == '0) ? 2'd2 : (row_p1_q == RW'(1)) ? 2'd1 : 2'd0;
      hmin     = (col_p1_q == '0) ? 2'd2 : (col_p1_q == CW'(1)) ? 2'd1 : 2'd0;
      border_d = (vmin != 2'd0) || (hmin != 2'd0);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
`ifdef WIN3X3_EDGE_REPLICATE_EN
            win_d[r][c] = raw[(2'(r) < vmin) ? vmin : 2'(r)][(2'(c) < hmin) ? hmin : 2'(c)];
`else
            win_d[r][c] = ((2'(r) < vmin) || (2'(c) < hmin)) ? '0 : raw[r][c];
`endif
         end
      end
   end

   // ---- stage p1 -> p2: horizontal shift and masked output window
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            h1_q[i] <= '0;
            h2_q[i] <= '0;
            h3_q[i] <= '0;
         end
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
         end
         o_de_q     <= 1'b0;
         o_border_q <= 1'b0;
         o_hs_q     <= 1'b0;
         o_vs_q     <= 1'b0;
      end else begin
         o_de_q     <= vld_p1_q;
         o_border_q <= vld_p1_q && border_d;
         o_hs_q     <= hs_p1_q;
         o_vs_q     <= vs_p1_q;
         if (vld_p1_q) begin
            h1_q[1] <= h1_q[0];  h1_q[0] <= lb2_rd_p1_q;
            h2_q[1] <= h2_q[0];  h2_q[0] <= lb1_rd_p1_q;
            h3_q[1] <= h3_q[0];  h3_q[0] <= in_p1_q;
            win_q   <= win_d;
         end
      end
   end

   assign bus.p11 = win_q[0][0];
   assign bus.p12 = win_q[0][1];
   assign bus.p13 = win_q[0][2];
   assign bus.p21 = win_q[1][0];
   assign bus.p22 = win_q[1][1];
   assign bus.p23 = win_q[1][2];
   assign bus.p31 = win_q[2][0];
   assign bus.p32 = win_q[2][1];
   assign bus.p33 = win_q[2][2];
   assign bus.o_de     = o_de_q;
   assign bus.o_border = o_border_q;
   assign bus.o_hsync  = o_hs_q;
   assign bus.o_vsync  = o_vs_q;
endmodule

// File: tb/tb_gray_win3x3_gen.sv
// Directed bench for gray_win3x3_gen on an 8x4 image; pixel(row,col) = 0x10*row + col + 1.
module tb_gray_win3x3_gen;
   localparam int DW = 8;
   localparam int W  = 8;
   localparam int H  = 4;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   gray_win3x3_gen_if #(.DATA_WIDTH(DW)) bus ();

   gray_win3x3_gen #(
      .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .VS_ACTIVE(1'b0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   int   n_chk = 0;
   int   n_err = 0;
   logic sync_chk = 1'b0;
   logic hs_prev = 1'b0;
   logic vs_prev = 1'b0;

   logic [7:0] cp  [0:15][0:8];
   logic       cde [0:15];
   logic       cbd [0:15];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int r, input int c);
      return 8'(16 * r + c + 1);
   endfunction

   // Expected tap t (row-major p11..p33) for the pixel at (r,c)
   function automatic logic [7:0] exp_tap(input int r, input int c, input int t);
      int rr, cc;
      rr = r - 2 + t / 3;
      cc = c - 2 + t % 3;
`ifdef WIN3X3_EDGE_REPLICATE_EN
      if (rr < 0) rr = 0;
      if (cc < 0) cc = 0;
      return pix(rr, cc);
`else
      if (rr < 0 || cc < 0) return 8'h00;
      return pix(rr, cc);
`endif
   endfunction

   task automatic cap(input int j);
      cp[j][0] = bus.p11;  cp[j][1] = bus.p12;  cp[j][2] = bus.p13;
      cp[j][3] = bus.p21;  cp[j][4] = bus.p22;  cp[j][5] = bus.p23;
      cp[j][6] = bus.p31;  cp[j][7] = bus.p32;  cp[j][8] = bus.p33;
      cde[j] = bus.o_de;
      cbd[j] = bus.o_border;
   endtask

   // One clock; syncs out must equal the syncs driven two cycles back
   task automatic tick();
      logic hs_c, vs_c;
      hs_c = bus.hsync;
      vs_c = bus.vsync;
      @(posedge clk);
      #1;
      if (sync_chk) begin
         chk("o_hsync delay", bus.o_hsync, hs_prev);
         chk("o_vsync delay", bus.o_vsync, vs_prev);
      end
      hs_prev = hs_c;
      vs_prev = vs_c;
   endtask

   // n de cycles of row r followed by a single idle cycle, then check every accepted pixel
   task automatic run_line(input int r, input int n);
      int cnt, nv;
      cnt = 0;
      nv  = (n < W) ? n : W;
      for (int k = 0; k <= n; k++) begin
         bus.de      = (k < n);
         bus.in_data = (k < n) ? pix(r, k) : 8'h00;
         bus.hsync   = (k % 3 == 1);
         bus.vsync   = 1'b1;
         tick();
         if (bus.o_de) cnt++;
         if (k >= 1) cap(k - 1);
      end
      chk($sformatf("r%0d o_de count", r), cnt, nv);
      for (int c = 0; c < nv; c++) begin
         chk($sformatf("r%0d c%0d o_de", r, c), cde[c], 1'b1);
         chk($sformatf("r%0d c%0d o_border", r, c), cbd[c], (r < 2 || c < 2));
         for (int t = 0; t < 9; t++)
            chk($sformatf("r%0d c%0d p%0d%0d", r, c, t / 3 + 1, t % 3 + 1), cp[c][t], exp_tap(r, c, t));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n     = 1'b0;
      bus.de      = 1'b0;
      bus.in_data = 8'h00;
      bus.hsync   = 1'b0;
      bus.vsync   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.de      = 1'b1;
         bus.in_data = 8'hA5 ^ 8'(k);
         bus.hsync   = (k % 2 == 0);
         bus.vsync   = (k % 2 == 1);
         tick();
      end
      cap(0);
      chk("reset o_de", cde[0], 1'b0);
      chk("reset o_border", cbd[0], 1'b0);
      chk("reset o_hsync", bus.o_hsync, 1'b0);
      chk("reset o_vsync", bus.o_vsync, 1'b0);
      for (int t = 0; t < 9; t++)
         chk($sformatf("reset p%0d%0d", t / 3 + 1, t % 3 + 1), cp[0][t], 8'h00);

      bus.de    = 1'b0;
      bus.hsync = 1'b0;
      bus.vsync = 1'b0;
      reset_n   = 1'b1;
      tick();
      tick();
      sync_chk  = 1'b1;
      bus.vsync = 1'b1;
      tick();

      run_line(0, 8);
      chk("r0c3 p33", cp[3][8], 8'h04);
      chk("r0c3 p32", cp[3][7], 8'h03);
      chk("r0c3 p31", cp[3][6], 8'h02);
      chk("r0c3 o_border", cbd[3], 1'b1);
`ifdef WIN3X3_EDGE_REPLICATE_EN
      for (int t = 0; t < 9; t++) chk("rep r0c0 tap", cp[0][t], 8'h01);
`else
      for (int t = 0; t < 6; t++) chk("r0c3 upper rows zero", cp[3][t], 8'h00);
`endif

      run_line(1, 8);
`ifdef WIN3X3_EDGE_REPLICATE_EN
      chk("rep r1c1 p11", cp[1][0], 8'h01);
      chk("rep r1c1 p12", cp[1][1], 8'h01);
      chk("rep r1c1 p21", cp[1][3], 8'h01);
      chk("rep r1c1 p22", cp[1][4], 8'h01);
      chk("rep r1c1 p13", cp[1][2], 8'h02);
      chk("rep r1c1 p23", cp[1][5], 8'h02);
      chk("rep r1c1 p33", cp[1][8], 8'h12);
`endif

      // frame restart: row counter must fall back to 0
      bus.de    = 1'b0;
      bus.vsync = 1'b0;
      repeat (3) tick();
      bus.vsync = 1'b1;
      tick();
      run_line(0, 8);
      chk("restart r0c3 o_border", cbd[3], 1'b1);
`ifndef WIN3X3_EDGE_REPLICATE_EN
      for (int t = 0; t < 6; t++) chk("restart r0c3 p1x/p2x zero", cp[3][t], 8'h00);
`endif

      run_line(1, 8);
      run_line(2, 8);
      chk("r2c2 p11", cp[2][0], 8'h01);
      chk("r2c2 p22", cp[2][4], 8'h12);
      chk("r2c2 p33", cp[2][8], 8'h23);
      chk("r2c2 p13", cp[2][2], 8'h03);
      chk("r2c2 p31", cp[2][6], 8'h21);
      chk("r2c2 o_border", cbd[2], 1'b0);

      // overlong line: the two extra pixels must not reach o_de or the RAMs
      run_line(3, 10);
      chk("long c8 o_de", cde[8], 1'b0);
      chk("long c9 o_de", cde[9], 1'b0);
      run_line(4, 8);
      chk("after long c0 p23", cp[0][5], 8'h31);
      chk("after long c1 p23", cp[1][5], 8'h32);
      chk("after long c1 p13", cp[1][2], 8'h22);
      chk("after long c7 p21", cp[7][3], 8'h36);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/gray_win3x3_gen.md
Name: gray_win3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator between rgb2ycbcr and image_relifing in the gray-image path.
- Takes the Y (gray) pixel stream with hsync/vsync/de.
- Buffers the two previous lines in on-chip line RAMs.
- Emits a causal 3x3 window per valid pixel, plus delayed syncs and a border flag, so relief/edge kernels downstream need no line storage.

Parameters:
- DATA_WIDTH, 8, pixel width.
- IMG_WIDTH, 1280, active pixels per line; line-RAM depth.
- IMG_HEIGHT, 720, active lines per frame; row-counter saturation value.
- VS_ACTIVE, 1'b0, vsync level that marks vertical blanking (frame restart).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_WIDTH  gray pixel, valid when de=1.
- hsync  in  1  line sync.
- vsync  in  1  frame sync.
- de  in  1  active-pixel enable.
- p11,p12,p13,p21,p22,p23,p31,p32,p33  out  DATA_WIDTH each  window; pRC: R=1 is line y-2, R=3 is line y; C=1 is column x-2, C=3 is column x.
- o_hsync  out  1  hsync delayed to match the window.
- o_vsync  out  1  vsync delayed to match the window.
- o_de  out  1  window valid.
- o_border  out  1  window contains out-of-image positions (row<2 or col<2).

Behaviour:
- Reset: all outputs 0, col/row counters 0, shift registers 0. Line-RAM contents are don't-care; border logic masks them.
- Clocking: clk and reset_n only. Reset is asynchronous, active-low.
- Column counter col:
  - +1 per cycle with de=1.
  - Cleared in the cycle de=0.
  - Saturates at IMG_WIDTH; pixels with col>=IMG_WIDTH are dropped (no RAM write, o_de stays 0 for them).
- Row counter row:
  - +1 on each de falling edge, saturating at IMG_HEIGHT.
  - Cleared while vsync==VS_ACTIVE; the clear wins if it coincides with a de fall.
- Line RAMs LB1 and LB2, depth IMG_WIDTH, synchronous read, read-before-write. For each accepted pixel (de=1, col<IMG_WIDTH):
  - Read LB1[col] and LB2[col].
  - Write in_data to LB1[col].
  - Write the old LB1[col] to LB2[col].
- Shift registers: three 3-deep horizontal registers, one each for line y, y-1 and y-2, fed from in_data (delayed one cycle to align with the RAM read), LB1 data and LB2 data.
- Latency:
  - A pixel (y,x) accepted at cycle t appears at p33 at cycle t+2, with p22=(y-1,x-1) and p11=(y-2,x-2).
  - o_de, o_hsync, o_vsync and o_border are the inputs / computed flag delayed by exactly 2 cycles.
- Border fill:
  - Default: positions with row-index<0 or col-index<0 output 0.
  - Applied on the output register, not by corrupting the RAMs.
- o_border: 1 when o_de=1 and (row<2 or col<2) for the emitted pixel; otherwise 0.
- When o_de=0, window outputs hold their last values. Consumers must qualify with o_de.
- Back-to-back lines with a 1-cycle de gap: col clears, row increments, and no window data is lost.
- Reset mid-frame:
  - Everything clears immediately.
  - The next accepted line is treated as row 0 (border-filled) until the next vsync realigns the frame.
- Counter widths: col is clog2(IMG_WIDTH+1); row is clog2(IMG_HEIGHT+1).

Optional Feature:
- Macro: WIN3X3_EDGE_REPLICATE_EN.
- Defined: out-of-image positions take the nearest valid pixel instead of 0.
  - Vertical: at row 0, lines y-1 and y-2 equal line y; at row 1, line y-2 equals line y-1.
  - Horizontal: at col 0, columns x-1 and x-2 equal column x; at col 1, column x-2 equals column x-1.
  - o_border is unchanged.
- Undefined: zero fill as described in Behaviour.

Test Plan:
Bench parameters are IMG_WIDTH=8, IMG_HEIGHT=4, and pixel(row,col)=0x10*row+col+0x01.
- Reset: hold reset_n=0, toggle inputs -> all outputs 0, o_de=0. Release and check the first window is still border-filled.
- Row 0, col 3 (value 0x04) accepted at t -> at t+2: o_de=1, p33=0x04, p32=0x03, p31=0x02, rows 1-2 all 0x00, o_border=1.
- Row 2, col 2 (0x23) -> at t+2: p11=0x01, p22=0x12, p33=0x23, p13=0x03, p31=0x21, o_border=0. Check o_hsync/o_vsync are exactly 2-cycle delayed copies.
- vsync driven to VS_ACTIVE after row 1, then a new line -> that line outputs p1x=p2x=0x00 and o_border=1, i.e. the row counter restarted.
- Line of 10 de cycles (IMG_WIDTH=8) -> o_de high exactly 8 cycles. The following line's p2x matches the first 8 pixels only, with no RAM corruption.
- With WIN3X3_EDGE_REPLICATE_EN: row 0, col 0 (0x01) -> all nine outputs 0x01. Row 1, col 1 (0x12) -> p11=p12=p21=p22=0x01, p33=0x12, p13=p23=0x02.
